fmc_initiator: RTL and testbench

Initiator (host) side of the multiplexed address/data FMC/PSRAM-style bus that the FPGA target implements. It accepts burst requests on a valid/ready interface, drives the address phase, counts the fixed access latency, then streams write beats from a data handshake or returns read beats on a valid strobe. Used as an on-FPGA bus master for loopback bring-up against the target block, and as the reference driver in target benches.

---
 rtl/fmc_pkg.sv | 17 +
 rtl/fmc_initiator_if.sv | 34 +++
 rtl/fmc_data_bus.sv | 16 +
 rtl/fmc_initiator.sv | 156 +++++++++++++++
 tb/tb_fmc_initiator.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fmc_pkg.sv
// Shared FMC bus definitions: controller state encoding and default access latency.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fmc_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        LAT,
        DATA,
        TURN
    } state_t;

    // Must stay equal to the latency the target counts, or beats misalign.
    localparam int LatencyDefault = 2;

endpackage

// File: rtl/fmc_initiator_if.sv
// Request/write/read handshake bundle between a burst requester and the FMC initiator.
// Latency: n/a (wires only).
// Backpressure: req and wdata use valid/ready; rdata is a strobe with no backpressure.
interface fmc_initiator_if #(
    parameter int AddrWidth = 16,
    parameter int DataWidth = 16,
    parameter int MaxBurst  = 16
);
    localparam int LenWidth = $clog2(MaxBurst);

    logic                 req_valid_i;
    logic                 req_ready_o;
    logic                 req_we_i;
    logic [AddrWidth-1:0] req_addr_i;
    logic [LenWidth-1:0]  req_len_i;
    logic [DataWidth-1:0] wdata_i;
    logic                 wdata_valid_i;
    logic                 wdata_ready_o;
    logic [DataWidth-1:0] rdata_o;
    logic                 rdata_valid_o;

    // Requester side.
    modport master (
        output req_valid_i, req_we_i, req_addr_i, req_len_i, wdata_i, wdata_valid_i,
        input  req_ready_o, wdata_ready_o, rdata_o, rdata_valid_o
    );

    // Initiator side.
    modport slave (
        input  req_valid_i, req_we_i, req_addr_i, req_len_i, wdata_i, wdata_valid_i,
        output req_ready_o, wdata_ready_o, rdata_o, rdata_valid_o
    );

endinterface

// File: rtl/fmc_data_bus.sv
// Tristate buffer for the multiplexed address/data pins.
// Latency: combinational.
// Backpressure: none.
module fmc_data_bus #(
    parameter int DataWidth = 16
) (
    input  logic                 tristate_out,
    input  logic [DataWidth-1:0] out_dat,
    output logic [DataWidth-1:0] in_dat,
    inout  wire  [DataWidth-1:0] data_io
);

    assign data_io = tristate_out ? {DataWidth{1'bz}} : out_dat;
    assign in_dat  = data_io;

endmodule

// File: rtl/fmc_initiator.sv
// FMC/PSRAM-style bus master: address phase, fixed latency, then write or read beats.
// Latency: ADDR one cycle after request accept; first beat LatencyCycles cycles later; read data one cycle after sampling.
// Backpressure: req_ready only in IDLE; wait_i stalls beats; write underflow idles the bus without a beat.
module fmc_initiator
    import fmc_pkg::*;
#(
    parameter int AddrWidth     = 16,
    parameter int DataWidth     = 16,
    parameter int LatencyCycles = LatencyDefault,
    parameter int MaxBurst      = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    fmc_initiator_if.slave       bus,
    output logic                 busy_o,
    inout  wire  [DataWidth-1:0] data_io,
    output logic                 cs_no,
    output logic                 adv_no,
    output logic                 oe_no,
    output logic                 we_no,
    input  logic                 wait_i
);

    localparam int LenWidth = $clog2(MaxBurst);
    localparam int CntWidth = LenWidth + 1;
    localparam int LatWidth = $clog2(LatencyCycles + 1);

    state_t               state;
    state_t               state_nxt;
    logic                 we_q;
    logic [AddrWidth-1:0] addr_q;
    logic [LenWidth-1:0]  len_q;
    logic [LatWidth-1:0]  lat_cnt;
    logic [CntWidth-1:0]  beat_cnt;
    logic [DataWidth-1:0] rdata_q;
    logic                 rdata_vld_q;
    logic                 beat;
    logic                 drive;
    logic                 tristate_out;
    logic [DataWidth-1:0] out_dat;
    logic [DataWidth-1:0] in_dat;
    logic                 req_ready;

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state <= IDLE;
        else         state <= state_nxt;
    end

    // Next state, pin strobes and handshake readies, all decoded from the current state.
    always_comb begin
        state_nxt         = state;
        cs_no             = 1'b1;
        adv_no            = 1'b1;
        oe_no             = 1'b1;
        we_no             = 1'b1;
        drive             = 1'b0;
        out_dat           = '0;
        req_ready         = 1'b0;
        bus.wdata_ready_o = 1'b0;
        beat              = 1'b0;
        unique case (state)
            IDLE: begin
                req_ready = rst_ni;
                if (bus.req_valid_i) state_nxt = ADDR;
            end
            ADDR: begin
                cs_no                   = 1'b0;
                adv_no                  = 1'b0;
                drive                   = 1'b1;
                out_dat[AddrWidth-1:0]  = addr_q;
                state_nxt               = LAT;
            end
            LAT: begin
                cs_no = 1'b0;
                if (lat_cnt == LatWidth'(LatencyCycles - 1)) state_nxt = DATA;
            end
            DATA: begin
                cs_no = 1'b0;
                if (we_q) begin
                    // Write strobe only on a real beat so the target never advances on a gap.
                    bus.wdata_ready_o = !wait_i;
                    beat              = bus.wdata_valid_i && !wait_i;
                    we_no             = !beat;
                    drive             = beat;
                    out_dat           = bus.wdata_i;
                end else begin
                    oe_no = wait_i;
                    beat  = !wait_i;
                end
                if (beat && (beat_cnt == CntWidth'(len_q))) state_nxt = TURN;
            end
            TURN: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Capture the burst descriptor on request acceptance.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            we_q   <= 1'b0;
            addr_q <= '0;
            len_q  <= '0;
        end else if (req_ready && bus.req_valid_i) begin
            we_q   <= bus.req_we_i;
            addr_q <= bus.req_addr_i;
            len_q  <= bus.req_len_i;
        end
    end

    // Latency and beat counters; the extra beat-counter bit avoids wrap at the maximum length.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lat_cnt  <= '0;
            beat_cnt <= '0;
        end else if (state == ADDR) begin
            lat_cnt  <= '0;
            beat_cnt <= '0;
        end else if (state == LAT) begin
            lat_cnt  <= lat_cnt + 1'b1;
        end else if (beat) begin
            beat_cnt <= beat_cnt + 1'b1;
        end
    end

    // Register read beats so each sampled word appears one cycle later as a single-cycle strobe.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rdata_q     <= '0;
            rdata_vld_q <= 1'b0;
        end else begin
            rdata_vld_q <= (state == DATA) && !we_q && !wait_i;
            if ((state == DATA) && !we_q && !wait_i) rdata_q <= in_dat;
        end
    end

    assign tristate_out      = !drive;
    assign bus.req_ready_o   = req_ready;
    assign bus.rdata_o       = rdata_q;
    assign bus.rdata_valid_o = rdata_vld_q;
    assign busy_o            = (state != IDLE);

    fmc_data_bus #(
        .DataWidth (DataWidth)
    ) u_bus (
        .tristate_out (tristate_out),
        .out_dat      (out_dat),
        .in_dat       (in_dat),
        .data_io      (data_io)
    );

endmodule

// File: tb/tb_fmc_initiator.sv
// Directed bench for fmc_initiator with a behavioural target and read/write scoreboards.
// Latency: n/a.
// Backpressure: wait_i and write-valid gaps are driven by the sequence.
module tb_fmc_initiator;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wait_i = 1'b0;
    logic        cs_n, adv_n, oe_n, we_n, busy;
    wire  [15:0] data_io;

    int checks = 0;
    int failures = 0;
    int rd_count = 0;
    int busy_run = 0;
    int last_burst = 0;
    logic hold_wvalid = 1'b0;

    logic [15:0] wq[$];
    logic [15:0] wexp[$];
    logic [15:0] rdq[$];

    logic [15:0] mem [0:255];
    logic [15:0] t_addr = '0;

    always #5 clk = ~clk;

    fmc_initiator_if #(.AddrWidth(16), .DataWidth(16), .MaxBurst(16)) bus_if ();

    fmc_initiator #(
        .AddrWidth(16), .DataWidth(16), .LatencyCycles(2), .MaxBurst(16)
    ) u_dut (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .bus     (bus_if),
        .busy_o  (busy),
        .data_io (data_io),
        .cs_no   (cs_n),
        .adv_no  (adv_n),
        .oe_no   (oe_n),
        .we_no   (we_n),
        .wait_i  (wait_i)
    );

    // An undriven bus reads as all ones.
    pullup (data_io);

    // Behavioural target: latch address, store on write strobes, present data while oe is low.
    assign data_io = (!cs_n && !oe_n) ? mem[t_addr[7:0]] : 16'hzzzz;
    always @(posedge clk) begin
        if (!cs_n && !adv_n) t_addr <= data_io;
        else if (!cs_n && !we_n) begin
            mem[t_addr[7:0]] <= data_io;
            t_addr <= t_addr + 16'd1;
        end else if (!cs_n && !oe_n) t_addr <= t_addr + 16'd1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Write-data feeder: presents queued beats, honours the gap control, pops on handshake.
    initial begin : feeder
        logic hs;
        bus_if.wdata_valid_i = 1'b0;
        bus_if.wdata_i = '0;
        forever begin
            @(negedge clk);
            hs = bus_if.wdata_valid_i && bus_if.wdata_ready_o;
            @(posedge clk);
            #2;
            if (hs && wq.size() > 0) wq.delete(0);
            bus_if.wdata_valid_i = (wq.size() > 0) && !hold_wvalid;
            bus_if.wdata_i = (wq.size() > 0) ? wq[0] : 16'h0000;
        end
    end

    // Output monitor: scoreboard for read strobes and write beats, busy-run length per burst.
    initial begin : monitor
        forever begin
            @(negedge clk);
            if (bus_if.rdata_valid_o) begin
                rd_count++;
                chk("rd_expected", 32'(rdq.size() != 0), 32'd1);
                if (rdq.size() != 0) chk("rdata", bus_if.rdata_o, rdq.pop_front());
            end
            if (!cs_n && !we_n) begin
                chk("wr_expected", 32'(wexp.size() != 0), 32'd1);
                if (wexp.size() != 0) chk("wr_beat", data_io, wexp.pop_front());
            end
            if (busy) busy_run++;
            else if (busy_run != 0) begin
                last_burst = busy_run;
                busy_run = 0;
            end
        end
    end

    initial begin : watchdog
        #50000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "timeout");
    end

    task automatic issue(input logic we, input logic [15:0] addr, input logic [3:0] len);
        logic got;
        got = 1'b0;
        @(posedge clk); #1;
        bus_if.req_valid_i = 1'b1;
        bus_if.req_we_i = we;
        bus_if.req_addr_i = addr;
        bus_if.req_len_i = len;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus_if.req_ready_o) begin
                got = 1'b1;
                break;
            end
        end
        chk("req_handshake", 32'(got), 32'd1);
        @(posedge clk); #1;
        bus_if.req_valid_i = 1'b0;
    endtask

    task automatic wait_idle();
        logic done;
        done = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!busy) begin
                done = 1'b1;
                break;
            end
        end
        #1;
        chk("idle_reached", 32'(done), 32'd1);
    endtask

    initial begin : seq
        int rd_before;
        bus_if.req_valid_i = 1'b0;
        bus_if.req_we_i = 1'b0;
        bus_if.req_addr_i = '0;
        bus_if.req_len_i = '0;

        // Reset state.
        #3;
        chk("rst_cs", cs_n, 1); chk("rst_adv", adv_n, 1);
        chk("rst_oe", oe_n, 1); chk("rst_we", we_n, 1);
        chk("rst_req_ready", bus_if.req_ready_o, 0);
        chk("rst_wready", bus_if.wdata_ready_o, 0);
        chk("rst_rvalid", bus_if.rdata_valid_o, 0);
        chk("rst_busy", busy, 0);
        chk("rst_bus", data_io, 16'hFFFF);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("idle_req_ready", bus_if.req_ready_o, 1);

        // Single write: pin-level trace.
        wq.push_back(16'hBEEF); wexp.push_back(16'hBEEF);
        issue(1'b1, 16'h0010, 4'd0);
        @(negedge clk);
        chk("w1_addr_adv", adv_n, 0); chk("w1_addr_cs", cs_n, 0);
        chk("w1_addr_bus", data_io, 16'h0010); chk("w1_addr_we", we_n, 1);
        @(negedge clk);
        chk("w1_lat1_adv", adv_n, 1); chk("w1_lat1_bus", data_io, 16'hFFFF); chk("w1_lat1_we", we_n, 1);
        @(negedge clk);
        chk("w1_lat2_cs", cs_n, 0); chk("w1_lat2_we", we_n, 1);
        @(negedge clk);
        chk("w1_data_we", we_n, 0); chk("w1_data_bus", data_io, 16'hBEEF);
        @(negedge clk);
        chk("w1_turn_cs", cs_n, 1); chk("w1_turn_busy", busy, 1); chk("w1_turn_bus", data_io, 16'hFFFF);
        @(negedge clk);
        chk("w1_idle_busy", busy, 0); chk("w1_idle_ready", bus_if.req_ready_o, 1);
        chk("w1_mem", mem[8'h10], 16'hBEEF);

        // Four-beat write then read back.
        for (int i = 0; i < 4; i++) begin
            wq.push_back(16'(16'h1111 * (i + 1)));
            wexp.push_back(16'(16'h1111 * (i + 1)));
        end
        issue(1'b1, 16'h0010, 4'd3);
        wait_idle();
        chk("w4_cycles", last_burst, 8);
        for (int i = 0; i < 4; i++) chk("w4_mem", mem[8'h10 + i], 16'(16'h1111 * (i + 1)));
        for (int i = 0; i < 4; i++) rdq.push_back(16'(16'h1111 * (i + 1)));
        issue(1'b0, 16'h0010, 4'd3);
        wait_idle();
        chk("r4_cycles", last_burst, 8);
        chk("r4_drained", rdq.size(), 0);

        // Write underflow: two-cycle valid gap after the second beat.
        for (int i = 0; i < 4; i++) begin
            wq.push_back(16'(16'h5001 + i));
            wexp.push_back(16'(16'h5001 + i));
        end
        issue(1'b1, 16'h0020, 4'd3);
        repeat (4) @(posedge clk);
        @(posedge clk); #1 hold_wvalid = 1'b1;
        @(negedge clk);
        chk("uf1_we", we_n, 1); chk("uf1_bus", data_io, 16'hFFFF); chk("uf1_cs", cs_n, 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("uf2_we", we_n, 1); chk("uf2_bus", data_io, 16'hFFFF);
        @(posedge clk); #1 hold_wvalid = 1'b0;
        wait_idle();
        chk("uf_cycles", last_burst, 10);
        for (int i = 0; i < 4; i++) chk("uf_mem", mem[8'h20 + i], 16'(16'h5001 + i));

        // Read with wait_i high for three DATA cycles after the first beat.
        for (int i = 0; i < 4; i++) rdq.push_back(16'(16'h1111 * (i + 1)));
        issue(1'b0, 16'h0010, 4'd3);
        repeat (3) @(posedge clk);
        @(posedge clk); #1 wait_i = 1'b1;
        @(negedge clk);
        chk("wt1_oe", oe_n, 1); chk("wt1_rvalid", bus_if.rdata_valid_o, 1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("wt2_oe", oe_n, 1); chk("wt2_rvalid", bus_if.rdata_valid_o, 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("wt3_oe", oe_n, 1); chk("wt3_rvalid", bus_if.rdata_valid_o, 0);
        @(posedge clk); #1 wait_i = 1'b0;
        wait_idle();
        chk("wt_cycles", last_burst, 11);
        chk("wt_drained", rdq.size(), 0);

        // Back-to-back single reads with req_valid held high.
        rdq.push_back(16'h1111); rdq.push_back(16'h2222);
        @(posedge clk); #1;
        bus_if.req_valid_i = 1'b1; bus_if.req_we_i = 1'b0;
        bus_if.req_addr_i = 16'h0010; bus_if.req_len_i = 4'd0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus_if.req_ready_o) break;
        end
        @(posedge clk); #1 bus_if.req_addr_i = 16'h0011;
        @(negedge clk);
        chk("b2b_addr1_adv", adv_n, 0); chk("b2b_addr1_bus", data_io, 16'h0010);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("b2b_beat_oe", oe_n, 0);
        @(negedge clk);
        chk("b2b_turn_cs", cs_n, 1); chk("b2b_turn_ready", bus_if.req_ready_o, 0);
        @(negedge clk);
        chk("b2b_idle_ready", bus_if.req_ready_o, 1); chk("b2b_idle_busy", busy, 0);
        @(posedge clk); #1 bus_if.req_valid_i = 1'b0;
        @(negedge clk);
        chk("b2b_addr2_adv", adv_n, 0); chk("b2b_addr2_bus", data_io, 16'h0011);
        wait_idle();
        chk("b2b_drained", rdq.size(), 0);

        // Reset during the second beat of a four-beat read.
        rdq.push_back(16'h1111);
        issue(1'b0, 16'h0010, 4'd3);
        repeat (3) @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("mr_cs", cs_n, 1); chk("mr_oe", oe_n, 1); chk("mr_adv", adv_n, 1); chk("mr_we", we_n, 1);
        chk("mr_busy", busy, 0); chk("mr_ready", bus_if.req_ready_o, 0);
        chk("mr_rvalid", bus_if.rdata_valid_o, 0); chk("mr_bus", data_io, 16'hFFFF);
        rd_before = rd_count;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("mr_release_ready", bus_if.req_ready_o, 1);
        repeat (5) @(negedge clk);
        chk("mr_no_strobes", rd_count, rd_before);
        chk("mr_drained", rdq.size(), 0);
        chk("wexp_drained", wexp.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
